nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer that performs WIDTH-bit additions by reusing one 4-bit ripple-carry
//  adder slice (four chained FA cells) over successive cycles, one nibble per cycle.
//  A registered carry chains the nibbles together. Operands are latched on a
//  start/busy/done handshake. Sits between switch/register operand sources and the
//  LEDR/HEX result display.
// PARAMETERS
//  WIDTH    16  operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4  derived number of adder passes; not user-set
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      request a new addition; sampled on rising clk edge
//  a          in   WIDTH  operand A, latched when start is accepted
//  b          in   WIDTH  operand B, latched when start is accepted
//  cin        in   1      carry-in to nibble 0, latched when start is accepted
//  busy       out  1      high while in ADD state
//  done       out  1      one-cycle pulse: result valid
//  sum        out  WIDTH  result, held stable from done until next accepted start
//  cout       out  1      unsigned carry-out of the MSB nibble, held like sum
//  ovf        out  1      signed overflow (carry into MSB xor carry out of MSB), held like sum
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0,
//    nibble index=0, carry reg=0, operand regs=0.
//  - FSM states: IDLE, ADD, DONE.
//    IDLE: start=1 -> latch a,b,cin; idx=0; carry=cin; go to ADD.
//    ADD : each cycle adds opA[idx], opB[idx] and carry through the 4-bit slice;
//          writes sum[4*idx+3:4*idx]; carry<=slice carry-out; idx<=idx+1.
//          When idx==NIBBLES-1, the same edge writes cout and ovf and moves to DONE.
//    DONE: done=1 for exactly this cycle. start=1 -> accept (as in IDLE) and go to ADD;
//          otherwise go to IDLE.
//  - Latency: start accepted at edge k -> nibble writes at edges k+1..k+NIBBLES ->
//    done high during cycle after edge k+NIBBLES (WIDTH=16: 4 cycles).
//  - Throughput: one addition per NIBBLES+1 cycles when start is held high.
//  - busy=1 exactly in ADD; start during ADD is ignored; latched operands are never
//    re-sampled mid-operation.
//  - sum bits are written nibble by nibble: intermediate sum is undefined for
//    consumers; only sum/cout/ovf qualified by done (or later, until next start)
//    are valid. On accepted start, sum/cout/ovf are held at the previous result
//    until overwritten.
//  - Arithmetic is modulo 2^WIDTH; cout = bit WIDTH of a+b+cin.
//    ovf = carry into bit WIDTH-1 xor cout, taken from the MSB nibble's internal
//    bit-2 -> bit-3 carry.
//  - idx wraps only via restart; it never exceeds NIBBLES-1 in ADD.
//  - Reset asserted mid-ADD aborts the operation; no done pulse is produced.
//    After release the block idles until a new start.
//  - start and reset asserted together: reset wins.
// TESTING (WIDTH=16)
//  - a=0xFFFF, b=0x0001, cin=0, start 1 cycle -> busy 4 cycles; done with
//    sum=0x0000, cout=1, ovf=0.
//  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1;
//    a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
//  - a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0; done exactly 4 edges
//    after the start edge.
//  - Start accepted, then a/b changed and start pulsed during ADD -> result is from
//    original operands; no extra done pulse.
//  - start held high continuously with fixed operands -> done every 5 cycles; busy
//    low only in DONE cycles.
//  - reset pulsed 2 cycles into ADD -> all outputs 0, no done. New start afterwards
//    completes normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one nibble per cycle,
// with a start/busy/done handshake and a result held until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start
// ADD   | one nibble per cycle through the slice, carry chained in a register
// DONE  | one-cycle result-valid pulse; start here restarts immediately
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_d;
    logic             accept;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;
    logic [3:0]       nib_a, nib_b, slice_s;
    logic [4:0]       slice_c;

    // Four chained full-adder cells; slice_c[3] is the carry into the slice MSB.
    always_comb begin
        nib_a      = opa[{idx, 2'b00} +: 4];
        nib_b      = opb[{idx, 2'b00} +: 4];
        slice_s    = '0;
        slice_c    = '0;
        slice_c[0] = carry;
        for (int i = 0; i < 4; i++) begin
            slice_s[i]   = nib_a[i] ^ nib_b[i] ^ slice_c[i];
            slice_c[i+1] = (nib_a[i] & nib_b[i]) | (slice_c[i] & (nib_a[i] ^ nib_b[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (idx == LAST) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == ADD) begin
            sum[{idx, 2'b00} +: 4] <= slice_s;
            carry                  <= slice_c[4];
            if (idx == LAST) begin
                cout <= slice_c[4];
                ovf  <= slice_c[3] ^ slice_c[4];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl (WIDTH=16) against a
// whole-word arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    localparam int W     = 16;
    localparam int LIMIT = 20;

    logic         clk = 1'b0;
    logic         reset, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int vectors     = 0;
    int miscompares = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from plain word arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] full;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {o, full};
    endfunction

    // Pulses start for one cycle; returns at the following negedge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done, and busy samples seen on the way; bounded by LIMIT.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < LIMIT) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
        logic [W-1:0] tb [4] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556};
        logic         ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic         eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat, bn;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], tc[i]);
            wait_done(lat, bn);
            vectors++;
            if (lat !== 4 || bn !== 4) begin
                miscompares++;
                $display("FAIL directed_timing[%0d]: got latency=%0d busy_cycles=%0d, want 4 4",
                         i, lat, bn);
            end
            vectors++;
            if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, want %h %b %b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || sum !== es[i] || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_hold[%0d]: got done=%b busy=%b sum=%h, want 0 0 %h",
                         i, done, busy, sum, es[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        logic         c;
        logic [W+1:0] exp;
        int lat, bn;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            exp = model(x, y, c);
            launch(x, y, c);
            wait_done(lat, bn);
            vectors++;
            if ({ovf, cout, sum} !== exp || lat !== 4) begin
                miscompares++;
                $display("FAIL random[%0d] %h+%h+%b: got ovf/cout/sum=%b/%b/%h lat=%0d, want %b/%b/%h lat=4",
                         i, x, y, c, ovf, cout, sum, lat, exp[W+1], exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_ignore_start_in_add;
        logic [W-1:0] x, y;
        logic         c;
        logic [W+1:0] exp;
        int lat, bn, extra;
        x = W'($urandom); y = W'($urandom); c = 1'($urandom);
        exp = model(x, y, c);
        launch(x, y, c);
        a = ~x; b = y ^ 16'h5A5A; cin = ~c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn);
        vectors++;
        if ({ovf, cout, sum} !== exp || lat >= LIMIT) begin
            miscompares++;
            $display("FAIL ignore_start_result: got ovf/cout/sum=%b/%b/%h timeout=%0d, want %b/%b/%h",
                     ovf, cout, sum, lat >= LIMIT, exp[W+1], exp[W], exp[W-1:0]);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_start_extra_done: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] exp;
        int last, ndone;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        exp = model(a, b, cin);
        start = 1'b1;
        last = 0; ndone = 0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            vectors++;
            if (busy !== ~done) begin
                miscompares++;
                $display("FAIL b2b_busy[%0d]: got busy=%b done=%b, want busy=!done", s, busy, done);
            end
            if (done) begin
                ndone++;
                vectors++;
                if ({ovf, cout, sum} !== exp || (last != 0 && s - last != 5)) begin
                    miscompares++;
                    $display("FAIL b2b_done[%0d]: got ovf/cout/sum=%b/%b/%h gap=%0d, want %b/%b/%h gap=5",
                             s, ovf, cout, sum, s - last, exp[W+1], exp[W], exp[W-1:0]);
                end
                last = s;
            end
        end
        start = 1'b0;
        vectors++;
        if (ndone !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d done pulses in 20 cycles, want 4", ndone);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_add;
        logic [W-1:0] x, y;
        logic         c;
        logic [W+1:0] exp;
        int lat, bn, pulses;
        launch(16'hABCD, 16'h1357, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            miscompares++;
            $display("FAIL midadd_reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL midadd_no_done: got %0d busy/done cycles after abort, want 0", pulses);
        end
        x = W'($urandom); y = W'($urandom); c = 1'($urandom);
        exp = model(x, y, c);
        launch(x, y, c);
        wait_done(lat, bn);
        vectors++;
        if ({ovf, cout, sum} !== exp || lat !== 4) begin
            miscompares++;
            $display("FAIL midadd_restart: got ovf/cout/sum=%b/%b/%h lat=%0d, want %b/%b/%h lat=4",
                     ovf, cout, sum, lat, exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start_in_add();
        test_back_to_back();
        test_reset_mid_add();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
